dt_peak_scan: RTL and testbench
===============================

# dt_peak_scan

Post-processing stage downstream of the distance-transform engine. Once the engine signals completion, it streams the full 128x128 distance map back out of the shared result RAM. It reports the peak distance value, the raster-first address where that peak occurs, and how many pixels reach it. Results feed the host/testbench as the "largest inscribed square" summary of the binary image.

## Interface
- `IMG_W`, default 128: image width and height, in pixels.
- `ADDR_W`, default 14: result RAM address width (IMG_W*IMG_W = 16384 words).
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: level request to scan; tied to the DT engine `done`.
- `res_rd`, output, 1: result RAM read enable.
- `res_addr`, output, ADDR_W: result RAM read address.
- `res_di`, input, 8: result RAM read data; valid one cycle after address/rd.
- `done`, output, 1: scan complete and results valid; level.
- `peak_val`, output, 8: maximum distance value found.
- `peak_addr`, output, ADDR_W: lowest raster address holding `peak_val`.
- `peak_cnt`, output, ADDR_W+1: number of pixels equal to `peak_val` (0 if `peak_val`=0).

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: `res_rd`=0. If `start`=1 at an edge, the block does the following and moves to SCAN:
  - clears `peak_val`, `peak_addr`, `peak_cnt`;
  - sets `res_addr`<=0 and `res_rd`<=1.
- SCAN: on each edge, increments `res_addr` by 1 and processes `res_di` for the address issued one cycle earlier. The first SCAN edge has no valid data; this is tracked by a 1-bit valid register. After the edge that issues address 2^ADDR_W-1, the next edge does the following and moves to DRAIN:
  - holds `res_addr` (no wrap to 0);
  - sets `res_rd`<=0.
- DRAIN: processes the last word (address 16383), sets `done`<=1, and moves to DONE.
- DONE: all outputs are held. When `start`=0, the block sets `done`<=0 and returns to IDLE. Result registers keep their values until the next start.
- Update rule, with v = `res_di` and a = address of v:
  - if v > `peak_val`: `peak_val`<=v, `peak_addr`<=a, `peak_cnt`<=1;
  - else if v == `peak_val` and v != 0: `peak_cnt`<=`peak_cnt`+1;
  - otherwise no change.
- Ties keep the earliest address. An all-zero map gives `peak_val`=0, `peak_addr`=0, `peak_cnt`=0.
- Comparisons are 8-bit unsigned. `peak_cnt` cannot overflow, because its maximum is 16384 and it is 15 bits wide.
- `start` is ignored in SCAN and DRAIN; deasserting it mid-scan does not abort the scan.
- `reset` asserted at any time returns the block to IDLE asynchronously.

## Timing
- Reset values: `res_rd`=0, `res_addr`=0, `done`=0, `peak_val`=0, `peak_addr`=0, `peak_cnt`=0, state=IDLE.
- Throughput: one RAM read per cycle, with no bubbles.
- Latency: call the edge where IDLE samples `start`=1 edge E0.
  - Addresses 0..16383 are presented after edges E0..E16383.
  - DRAIN is entered at E16384.
  - `done` rises at E16385.
- `done` falls one edge after `start` is sampled low in DONE.
- `start` held high continuously after `done` does not retrigger a scan; it must go low for at least one cycle first.

## Configuration
- `DT_SCAN_OBJCNT_EN`
- Defined: adds output `obj_cnt` (ADDR_W+1 bits, reset 0, cleared on scan start). It counts words with `res_di` != 0 during SCAN/DRAIN and is valid while `done`=1.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `dt_pkg`: `IMG_W`, `ADDR_W`, `PIX_NUM` (=16384), `LAST_ADDR` (=16383), and the scan state enum.
- Sub-module `dt_peak_cmp`: registered update unit. Inputs are v, a and a valid flag; outputs are `peak_val`, `peak_addr` and `peak_cnt`; it also has a synchronous clear. The top level holds the FSM, address counter and valid pipeline.

## Test plan
- All-zero map, pulse `start` -> `done` rises 16385 cycles after the start edge; `peak_val`=0, `peak_addr`=0, `peak_cnt`=0.
- Single nonzero word 5 at address 8321, rest 0 -> `peak_val`=5, `peak_addr`=8321, `peak_cnt`=1.
- Value 7 at addresses 300, 129 and 16254; value 6 elsewhere nonzero -> `peak_val`=7, `peak_addr`=129, `peak_cnt`=3.
- Value 9 at address 16383 only (checks DRAIN) -> `peak_val`=9, `peak_addr`=16383, `peak_cnt`=1.
- Deassert `start` at cycle 100, then reassert after `done`; next, assert `reset` at cycle 5000 of a second scan -> the first scan completes normally; `reset` forces IDLE with all outputs 0 immediately; a following start rescans correctly.
- With `DT_SCAN_OBJCNT_EN`: 14x14 block of value 1 -> `obj_cnt`=196, `peak_cnt`=196, `peak_val`=1.

Source files
------------

// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared sizes and scan FSM state codes for the distance-transform peak scanner
package dt_pkg;
  localparam int IMG_W     = 128;
  localparam int ADDR_W    = 14;
  localparam int PIX_NUM   = IMG_W * IMG_W;
  localparam int LAST_ADDR = PIX_NUM - 1;

  typedef logic [1:0] scan_state_t;
  localparam scan_state_t ST_IDLE  = 2'd0;
  localparam scan_state_t ST_SCAN  = 2'd1;
  localparam scan_state_t ST_DRAIN = 2'd2;
  localparam scan_state_t ST_DONE  = 2'd3;
endpackage

// File: rtl/dt_peak_cmp.sv
// rtl/dt_peak_cmp.sv - registered running max / first-address / tie-count update unit
module dt_peak_cmp #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              valid,
  input  logic [7:0]        v,
  input  logic [ADDR_W-1:0] a,
  output logic [7:0]        peak_val,
  output logic [ADDR_W-1:0] peak_addr,
  output logic [ADDR_W:0]   peak_cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_val  <= '0;
      peak_addr <= '0;
      peak_cnt  <= '0;
    end else if (clr) begin
      peak_val  <= '0;
      peak_addr <= '0;
      peak_cnt  <= '0;
    end else if (valid) begin
      // strict greater-than keeps the earliest raster address on ties
      if (v > peak_val) begin
        peak_val  <= v;
        peak_addr <= a;
        peak_cnt  <= {{ADDR_W{1'b0}}, 1'b1};
      end else if (v == peak_val && v != 8'd0) begin
        peak_cnt <= peak_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dt_peak_scan.sv
// rtl/dt_peak_scan.sv - streams the distance map out of result RAM and reports peak value/address/count; DT_SCAN_OBJCNT_EN adds obj_cnt
module dt_peak_scan
  import dt_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [7:0]        res_di,
  output logic              done,
  output logic [7:0]        peak_val,
  output logic [ADDR_W-1:0] peak_addr,
  output logic [ADDR_W:0]   peak_cnt
`ifdef DT_SCAN_OBJCNT_EN
  ,
  output logic [ADDR_W:0]   obj_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_W - 1);

  scan_state_t       state;
  logic              vld;
  logic              clr;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_addr;

  assign clr       = (state == ST_IDLE) && start;
  assign upd_valid = ((state == ST_SCAN) && vld) || (state == ST_DRAIN);
  // read data lags the address by one cycle, except in DRAIN where the address is held
  assign upd_addr  = (state == ST_DRAIN) ? res_addr : res_addr - ADDR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      res_rd   <= 1'b0;
      res_addr <= '0;
      done     <= 1'b0;
      vld      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            res_addr <= '0;
            res_rd   <= 1'b1;
            vld      <= 1'b0;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          vld <= 1'b1;
          if (res_addr == LAST) begin
            res_rd <= 1'b0;
            state  <= ST_DRAIN;
          end else begin
            res_addr <= res_addr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dt_peak_cmp #(.ADDR_W(ADDR_W)) u_cmp (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .valid     (upd_valid),
    .v         (res_di),
    .a         (upd_addr),
    .peak_val  (peak_val),
    .peak_addr (peak_addr),
    .peak_cnt  (peak_cnt)
  );

`ifdef DT_SCAN_OBJCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      obj_cnt <= '0;
    end else if (clr) begin
      obj_cnt <= '0;
    end else if (upd_valid && res_di != 8'd0) begin
      obj_cnt <= obj_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dt_peak_scan.sv
// tb/tb_dt_peak_scan.sv - scoreboard bench for dt_peak_scan against a whole-map reference model
module tb_dt_peak_scan;
  import dt_pkg::*;

  localparam int AW   = ADDR_W;
  localparam int NPIX = PIX_NUM;
  localparam int LAT  = NPIX + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          res_rd;
  logic [AW-1:0] res_addr;
  logic [7:0]    res_di = 8'd0;
  logic          done;
  logic [7:0]    peak_val;
  logic [AW-1:0] peak_addr;
  logic [AW:0]   peak_cnt;
`ifdef DT_SCAN_OBJCNT_EN
  logic [AW:0]   obj_cnt;
`endif

  dt_peak_scan #(.IMG_W(IMG_W), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .res_rd    (res_rd),
    .res_addr  (res_addr),
    .res_di    (res_di),
    .done      (done),
    .peak_val  (peak_val),
    .peak_addr (peak_addr),
    .peak_cnt  (peak_cnt)
`ifdef DT_SCAN_OBJCNT_EN
    ,
    .obj_cnt   (obj_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:NPIX-1];
  always @(posedge clk) if (res_rd) res_di <= mem[res_addr];

  typedef struct {
    int val;
    int addr;
    int cnt;
    int obj;
    int e0;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;
  int   cycle = 0;
  logic done_q = 1'b0;

  always @(posedge clk) cycle++;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // reference: maximum, its first occurrence and multiplicity over the whole map
  function automatic exp_t model();
    exp_t e;
    e.val = 0; e.addr = 0; e.cnt = 0; e.obj = 0; e.e0 = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (int'(mem[i]) != 0) e.obj++;
      if (int'(mem[i]) > e.val) begin
        e.val  = int'(mem[i]);
        e.addr = i;
      end
    end
    if (e.val != 0)
      for (int i = 0; i < NPIX; i++) if (int'(mem[i]) == e.val) e.cnt++;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("peak_val", int'(peak_val), mon_e.val);
        chk("peak_addr", int'(peak_addr), mon_e.addr);
        chk("peak_cnt", int'(peak_cnt), mon_e.cnt);
        chk("done_latency", cycle - mon_e.e0, LAT);
`ifdef DT_SCAN_OBJCNT_EN
        chk("obj_cnt", int'(obj_cnt), mon_e.obj);
`endif
      end
    end
    done_q = done;
  end

  task automatic issue_scan();
    exp_t e;
    @(negedge clk);
    e = model();
    e.e0 = cycle + 1;
    sbq.push_back(e);
    start = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < LAT + 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(done), 1);
  endtask

  // start held high past done: no retrigger, then done drops one edge after start falls
  task automatic close_scan_held();
    repeat (8) @(negedge clk);
    chk("held_done", int'(done), 1);
    chk("held_res_rd", int'(res_rd), 0);
    start = 1'b0;
    @(negedge clk);
    chk("done_fall", int'(done), 0);
  endtask

  task automatic zero_mem();
    for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
  endtask

  initial begin
    int r0, c0;
    zero_mem();
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_res_rd", int'(res_rd), 0);
    chk("rst_res_addr", int'(res_addr), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_peak_val", int'(peak_val), 0);
    chk("rst_peak_addr", int'(peak_addr), 0);
    chk("rst_peak_cnt", int'(peak_cnt), 0);
    reset = 1'b0;
    @(negedge clk);

    // all-zero map, start dropped mid-scan
    issue_scan();
    repeat (100) @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
    chk("done_fall_short", int'(done), 0);

    // single 5
    zero_mem();
    mem[8321] = 8'd5;
    issue_scan();
    wait_done();
    close_scan_held();

    // three 7s among random 6/0
    for (int i = 0; i < NPIX; i++) mem[i] = ($urandom_range(0, 1) != 0) ? 8'd6 : 8'd0;
    mem[300] = 8'd7; mem[129] = 8'd7; mem[16254] = 8'd7;
    issue_scan();
    wait_done();
    close_scan_held();

    // peak only in the drained last word
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(0, 8));
    mem[NPIX-1] = 8'd9;
    issue_scan();
    wait_done();
    close_scan_held();

    // scan aborted by reset at cycle 5000
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(0, 255));
    @(negedge clk);
    start = 1'b1;
    repeat (5000) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_res_rd", int'(res_rd), 0);
    chk("arst_res_addr", int'(res_addr), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_peak_val", int'(peak_val), 0);
    chk("arst_peak_addr", int'(peak_addr), 0);
    chk("arst_peak_cnt", int'(peak_cnt), 0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // 14x14 block of ones at a random position
    zero_mem();
    r0 = $urandom_range(0, IMG_W - 14);
    c0 = $urandom_range(0, IMG_W - 14);
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 14; c++) mem[(r0 + r) * IMG_W + c0 + c] = 8'd1;
    issue_scan();
    wait_done();
    close_scan_held();

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
